// File: rtl/seg_scan_driver.sv
// ============================================================================
// Module   : seg_scan_driver
// Brief    : Time-multiplexed 6-digit 7-segment scanner. Snapshots a packed
//            BCD value and decimal-point mask once per frame, then walks an
//            active-low digit select while driving the shared active-low
//            segment bus {dp,g,f,e,d,c,b,a}.
// Options  : SEG_SCAN_LZ_BLANK_EN - when defined, leading zeros of the
//            snapshot are blanked (digit 0 is always shown).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_scan_driver #(
  parameter logic [15:0] STAY_TIME  = 16'd50_000,
  parameter int          NUM_DIGITS = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] num,
  input  logic [5:0]  dp_mask,
  output logic [5:0]  sel,
  output logic [7:0]  seg
);

  // A dwell of zero would never let the counter match; treat it as one cycle.
  localparam logic [15:0] C_DWELL_LAST = (STAY_TIME == 16'd0) ? 16'd0 : (STAY_TIME - 16'd1);
  localparam logic [2:0]  C_IDX_LAST   = 3'd5;

  // Only a six-digit arrangement is implemented.
  if (NUM_DIGITS != 6) begin : g_cfg_check
    $error("seg_scan_driver supports NUM_DIGITS == 6 only");
  end

  // Active-low 7-segment decode {g,f,e,d,c,b,a}; non-BCD nibbles show a dash.
  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  logic [15:0] dwell_q,    dwell_d;
  logic [2:0]  idx_q,      idx_d;
  logic [23:0] snap_num_q, snap_num_d;
  logic [5:0]  snap_dp_q,  snap_dp_d;
  logic        primed_q,   primed_d;
  logic [5:0]  sel_q,      sel_d;
  logic [7:0]  seg_q,      seg_d;

  logic        w_dwell_end;
  logic        w_frame_wrap;
  logic        w_capture;
  logic [3:0]  w_nibble;
  logic [5:0]  w_blank;
  logic [7:0]  w_seg_digit;

  // Dwell/frame boundary detection and snapshot trigger.
  always_comb begin
    w_dwell_end  = (dwell_q == C_DWELL_LAST);
    w_frame_wrap = primed_q && w_dwell_end && (idx_q == C_IDX_LAST);
    // The very first cycle after reset also captures so the first frame has data.
    w_capture    = !primed_q || w_frame_wrap;
  end

  // Leading-zero blanking mask computed from the snapshot (all clear when disabled).
  always_comb begin
    logic run_zero;
    w_blank  = '0;
    run_zero = 1'b1;
`ifdef SEG_SCAN_LZ_BLANK_EN
    // Walk from the most significant digit down; a digit blanks only while
    // it and everything above it are zero. Digit 0 is excluded.
    for (int k = 5; k >= 1; k--) begin
      run_zero   = run_zero && (snap_num_q[4*k +: 4] == 4'h0);
      w_blank[k] = run_zero;
    end
`else
    run_zero = 1'b0;
`endif
  end

  // Segment pattern for the digit currently indexed.
  always_comb begin
    w_nibble    = snap_num_q[{idx_q, 2'b00} +: 4];
    w_seg_digit = w_blank[idx_q] ? 8'hFF : {~snap_dp_q[idx_q], decode(w_nibble)};
  end

  // Next-state for counter, index, snapshot and registered outputs.
  always_comb begin
    dwell_d    = dwell_q;
    idx_d      = idx_q;
    primed_d   = 1'b1;
    snap_num_d = snap_num_q;
    snap_dp_d  = snap_dp_q;
    sel_d      = sel_q;
    seg_d      = seg_q;

    // Scanning begins only once the first snapshot is held, so the first
    // visible digit lands on the second clock after reset release.
    if (primed_q) begin
      if (w_dwell_end) begin
        dwell_d = 16'd0;
        idx_d   = (idx_q == C_IDX_LAST) ? 3'd0 : (idx_q + 3'd1);
      end else begin
        dwell_d = dwell_q + 16'd1;
      end
      sel_d = ~(6'b00_0001 << idx_q);
      seg_d = w_seg_digit;
    end

    if (w_capture) begin
      snap_num_d = num;
      snap_dp_d  = dp_mask;
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_q    <= 16'd0;
      idx_q      <= 3'd0;
      snap_num_q <= 24'd0;
      snap_dp_q  <= 6'd0;
      primed_q   <= 1'b0;
      sel_q      <= 6'b11_1111;
      seg_q      <= 8'hFF;
    end else begin
      dwell_q    <= dwell_d;
      idx_q      <= idx_d;
      snap_num_q <= snap_num_d;
      snap_dp_q  <= snap_dp_d;
      primed_q   <= primed_d;
      sel_q      <= sel_d;
      seg_q      <= seg_d;
    end
  end

  assign sel = sel_q;
  assign seg = seg_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
// ============================================================================
// Module   : tb_seg_scan_driver
// Brief    : Directed self-checking bench for seg_scan_driver. Two instances
//            run side by side: dwell of 4 cycles and dwell of 1 cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] num = 24'd0;
  logic [5:0]  dp_mask = 6'd0;
  logic [5:0]  sel4, sel1;
  logic [7:0]  seg4, seg1;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp60 [6];
  logic [7:0] exp59 [6];
  logic [7:0] expa  [6];
  logic [7:0] exp0  [6];
  logic [7:0] hi;

  seg_scan_driver #(.STAY_TIME(16'd4), .NUM_DIGITS(6)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .num(num), .dp_mask(dp_mask), .sel(sel4), .seg(seg4)
  );

  seg_scan_driver #(.STAY_TIME(16'd1), .NUM_DIGITS(6)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .num(num), .dp_mask(dp_mask), .sel(sel1), .seg(seg1)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] sel_exp(input int d);
    logic [5:0] one;
    one = 6'b00_0001;
    return {2'b00, ~(one << d)};
  endfunction

  initial begin
`ifdef SEG_SCAN_LZ_BLANK_EN
    hi = 8'hFF;
`else
    hi = 8'hC0;
`endif
    exp60 = '{8'hC0, 8'h82, hi, hi, hi, hi};
    exp59 = '{8'h90, 8'h92, hi, hi, hi, hi};
    expa  = '{8'h3F, hi, hi, hi, hi, hi};
    exp0  = '{8'hC0, hi, hi, hi, hi, hi};

    // Reset held
    num = 24'h000060;
    dp_mask = 6'd0;
    rst_n = 1'b0;
    repeat (3) step();
    chk("rst_sel4", {2'b00, sel4}, 8'h3F);
    chk("rst_seg4", seg4, 8'hFF);
    chk("rst_sel1", {2'b00, sel1}, 8'h3F);
    chk("rst_seg1", seg1, 8'hFF);

    // Release: first edge still blank, digit 0 appears on second edge
    rst_n = 1'b1;
    step();
    chk("edge1_sel4", {2'b00, sel4}, 8'h3F);
    chk("edge1_seg4", seg4, 8'hFF);

    // Frame 1: 24-cycle frame on dwell-4, four 6-cycle frames on dwell-1
    for (int n = 0; n < 24; n++) begin
      step();
      chk("f1_sel4", {2'b00, sel4}, sel_exp(n / 4));
      chk("f1_seg4", seg4, exp60[n / 4]);
      chk("f1_sel1", {2'b00, sel1}, sel_exp(n % 6));
      chk("f1_seg1", seg1, exp60[n % 6]);
    end

    // Frame 2: num changes mid-frame; display keeps the snapshot
    for (int n = 0; n < 24; n++) begin
      step();
      chk("f2_sel4", {2'b00, sel4}, sel_exp(n / 4));
      chk("f2_seg4", seg4, exp60[n / 4]);
      if (n == 8) num = 24'h000059;
    end

    // Frame 3: new value shown; stop while digit 3 is displayed
    for (int n = 0; n <= 12; n++) begin
      step();
      chk("f3_sel4", {2'b00, sel4}, sel_exp(n / 4));
      chk("f3_seg4", seg4, exp59[n / 4]);
    end

    // Asynchronous reset mid-scan, away from any clock edge
    num = 24'h00000A;
    dp_mask = 6'b00_0001;
    #2 rst_n = 1'b0;
    #1;
    chk("async_sel4", {2'b00, sel4}, 8'h3F);
    chk("async_seg4", seg4, 8'hFF);
    chk("async_sel1", {2'b00, sel1}, 8'h3F);
    chk("async_seg1", seg1, 8'hFF);
    step();
    chk("hold_sel4", {2'b00, sel4}, 8'h3F);

    // Restart with a fresh snapshot: dash with DP on digit 0
    rst_n = 1'b1;
    step();
    chk("re_edge1_sel4", {2'b00, sel4}, 8'h3F);
    chk("re_edge1_seg1", seg1, 8'hFF);
    for (int n = 0; n < 6; n++) begin
      step();
      chk("re_sel1", {2'b00, sel1}, sel_exp(n));
      chk("re_seg1", seg1, expa[n]);
      chk("re_sel4", {2'b00, sel4}, sel_exp(n / 4));
      chk("re_seg4", seg4, expa[n / 4]);
    end
    step();
    chk("wrap_sel1", {2'b00, sel1}, 8'h3E);
    chk("wrap_seg1", seg1, 8'h3F);

    // All-zero value: captured at the next dwell-1 frame wrap
    num = 24'h000000;
    dp_mask = 6'd0;
    repeat (5) step();
    for (int n = 0; n < 6; n++) begin
      step();
      chk("zero_sel1", {2'b00, sel1}, sel_exp(n));
      chk("zero_seg1", seg1, exp0[n]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
